// File: rtl/memory_arbiter_pkg.sv
// Shared types for the two-requester memory arbiter: ownership FSM states and requester indices.
// Pure declarations; no latency or flow control of its own.
package memory_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OWNED0 = 2'd1,
        OWNED1 = 2'd2
    } state_t;

    localparam logic REQUESTER0 = 1'b0;
    localparam logic REQUESTER1 = 1'b1;

endpackage

// File: rtl/arbiter_response.sv
// Per-requester completion register: one-cycle rsp pulse plus captured read data.
// Latency 1 cycle after the granted transfer.
// No backpressure; a pulse is issued for every completed transfer.
module arbiter_response #(
    parameter int word_width = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  transfer,
    input  logic                  write,
    input  logic [word_width-1:0] mem_read_data,
    output logic                  rsp_valid,
    output logic [word_width-1:0] rsp_read_data
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid     <= 1'b0;
            rsp_read_data <= '0;
        end else begin
            rsp_valid <= transfer;
            // Writes leave the last read value visible to the requester.
            if (transfer && !write) begin
                rsp_read_data <= mem_read_data;
            end
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin arbiter of two requesters onto one single-port word memory, with lock ownership.
// Grant is combinational; completion pulse and read data arrive 1 cycle after the grant.
// Losing or locked-out requester sees ready low and holds its request.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int address_width = 32,
    parameter int word_width    = 32
) (
    input  logic                     clock,
    input  logic                     reset_n,

    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic                     req0_write,
    input  logic                     req0_lock,
    input  logic [address_width-1:0] req0_address,
    input  logic [word_width-1:0]    req0_write_data,
    output logic                     rsp0_valid,
    output logic [word_width-1:0]    rsp0_read_data,

    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic                     req1_write,
    input  logic                     req1_lock,
    input  logic [address_width-1:0] req1_address,
    input  logic [word_width-1:0]    req1_write_data,
    output logic                     rsp1_valid,
    output logic [word_width-1:0]    rsp1_read_data,

    output logic                     mem_write_enable,
    output logic [address_width-1:0] mem_address,
    output logic [word_width-1:0]    mem_write_data,
    input  logic [word_width-1:0]    mem_read_data
);

    state_t state, state_nxt;
    logic   rr_ptr, rr_ptr_nxt;
    logic   grant0, grant1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            rr_ptr <= REQUESTER1;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_ptr_nxt;
        end
    end

    always_comb begin
        grant0           = 1'b0;
        grant1           = 1'b0;
        state_nxt        = state;
        rr_ptr_nxt       = rr_ptr;
        mem_write_enable = 1'b0;
        mem_address      = '0;
        mem_write_data   = '0;

        case (state)
            IDLE: begin
                // rr_ptr holds the last winner, so the other side takes a contested cycle.
                if (req0_valid && req1_valid) begin
                    grant0 = (rr_ptr == REQUESTER1);
                    grant1 = (rr_ptr == REQUESTER0);
                end else begin
                    grant0 = req0_valid;
                    grant1 = req1_valid;
                end
            end
            OWNED0:  grant0 = req0_valid;
            OWNED1:  grant1 = req1_valid;
            default: ;
        endcase

        if (grant0) begin
            rr_ptr_nxt       = REQUESTER0;
            state_nxt        = req0_lock ? OWNED0 : IDLE;
            mem_write_enable = req0_write;
            mem_address      = req0_address;
            mem_write_data   = req0_write_data;
        end else if (grant1) begin
            rr_ptr_nxt       = REQUESTER1;
            state_nxt        = req1_lock ? OWNED1 : IDLE;
            mem_write_enable = req1_write;
            mem_address      = req1_address;
            mem_write_data   = req1_write_data;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    arbiter_response #(.word_width(word_width)) u_rsp0 (
        .clock         (clock),
        .reset_n       (reset_n),
        .transfer      (grant0),
        .write         (req0_write),
        .mem_read_data (mem_read_data),
        .rsp_valid     (rsp0_valid),
        .rsp_read_data (rsp0_read_data)
    );

    arbiter_response #(.word_width(word_width)) u_rsp1 (
        .clock         (clock),
        .reset_n       (reset_n),
        .transfer      (grant1),
        .write         (req1_write),
        .mem_read_data (mem_read_data),
        .rsp_valid     (rsp1_valid),
        .rsp_read_data (rsp1_read_data)
    );

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: stimulus pushes expected completions, a negedge monitor pops them.
// Memory words preload to 0xA5A50000 + 4*index.
module tb_memory_arbiter;

    typedef struct packed {
        logic        v;
        logic        w;
        logic        l;
        logic [31:0] a;
        logic [31:0] d;
    } rq_t;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req0_valid, req0_ready, req0_write, req0_lock;
    logic [31:0] req0_address, req0_write_data;
    logic        rsp0_valid;
    logic [31:0] rsp0_read_data;
    logic        req1_valid, req1_ready, req1_write, req1_lock;
    logic [31:0] req1_address, req1_write_data;
    logic        rsp1_valid;
    logic [31:0] rsp1_read_data;
    logic        mem_write_enable;
    logic [31:0] mem_address, mem_write_data, mem_read_data;

    logic [31:0] mem [0:63];
    exp_t        sbq [2][$];
    logic [31:0] last_rd [2];
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;

    memory_arbiter #(.address_width(32), .word_width(32)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .req0_valid       (req0_valid),
        .req0_ready       (req0_ready),
        .req0_write       (req0_write),
        .req0_lock        (req0_lock),
        .req0_address     (req0_address),
        .req0_write_data  (req0_write_data),
        .rsp0_valid       (rsp0_valid),
        .rsp0_read_data   (rsp0_read_data),
        .req1_valid       (req1_valid),
        .req1_ready       (req1_ready),
        .req1_write       (req1_write),
        .req1_lock        (req1_lock),
        .req1_address     (req1_address),
        .req1_write_data  (req1_write_data),
        .rsp1_valid       (rsp1_valid),
        .rsp1_read_data   (rsp1_read_data),
        .mem_write_enable (mem_write_enable),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_read_data    (mem_read_data)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    assign mem_read_data = mem[mem_address[7:2]];

    always @(posedge clock) begin
        if (mem_write_enable) mem[mem_address[7:2]] <= mem_write_data;
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] <= 32'hA5A5_0000 + 32'(i * 4);
    end

    function automatic rq_t rq(input logic v, input logic w, input logic l,
                               input logic [31:0] a, input logic [31:0] d);
        rq_t r;
        r.v = v; r.w = w; r.l = l; r.a = a; r.d = d;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon_one(input int n, input logic v, input logic [31:0] d);
        exp_t e;
        if (v) begin
            if (sbq[n].size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL rsp%0d_unexpected: got pulse with data %h, required no pulse (cycle %0d)", n, d, cyc);
            end else begin
                e = sbq[n].pop_front();
                check($sformatf("rsp%0d_cycle", n), 32'(cyc), 32'(e.cyc));
                check($sformatf("rsp%0d_data", n), d, e.data);
            end
        end else if (sbq[n].size() > 0 && sbq[n][0].cyc <= cyc) begin
            e = sbq[n].pop_front();
            vectors++;
            miscompares++;
            $display("FAIL rsp%0d_missing: got no pulse, required pulse with data %h (cycle %0d)", n, e.data, cyc);
        end
    endtask

    always @(negedge clock) begin
        mon_one(0, rsp0_valid, rsp0_read_data);
        mon_one(1, rsp1_valid, rsp1_read_data);
    end

    task automatic drive(input rq_t r0, input rq_t r1);
        req0_valid = r0.v; req0_write = r0.w; req0_lock = r0.l;
        req0_address = r0.a; req0_write_data = r0.d;
        req1_valid = r1.v; req1_write = r1.w; req1_lock = r1.l;
        req1_address = r1.a; req1_write_data = r1.d;
    endtask

    task automatic expect_rsp(input int n, input rq_t r, input logic [31:0] rd);
        exp_t e;
        check($sformatf("mem_we_g%0d", n), 32'(mem_write_enable), 32'(r.w));
        check($sformatf("mem_addr_g%0d", n), mem_address, r.a);
        check($sformatf("mem_wdata_g%0d", n), mem_write_data, r.d);
        e.cyc = cyc + 1;
        if (r.w) begin
            e.data = last_rd[n];
        end else begin
            e.data = rd;
            last_rd[n] = rd;
        end
        sbq[n].push_back(e);
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic step(input rq_t r0, input rq_t r1, input logic er0, input logic er1,
                        input logic [31:0] rd0, input logic [31:0] rd1);
        drive(r0, r1);
        #1;
        check("req0_ready", 32'(req0_ready), 32'(er0));
        check("req1_ready", 32'(req1_ready), 32'(er1));
        if (er0) expect_rsp(0, r0, rd0);
        else if (er1) expect_rsp(1, r1, rd1);
        else begin
            check("idle_mem_we", 32'(mem_write_enable), 32'd0);
            check("idle_mem_addr", mem_address, 32'd0);
            check("idle_mem_wdata", mem_write_data, 32'd0);
        end
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive(rq(0, 0, 0, 0, 0), rq(0, 0, 0, 0, 0));
        sbq[0].delete();
        sbq[1].delete();
        last_rd[0] = 32'd0;
        last_rd[1] = 32'd0;
        #1;
        check("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
        check("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
        check("rst_rsp0_data", rsp0_read_data, 32'd0);
        check("rst_rsp1_data", rsp1_read_data, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        rq_t idle;
        idle = rq(0, 0, 0, 0, 0);
        do_reset();

        // Contention: alternating grants starting with requester 0.
        step(rq(1, 0, 0, 32'h0, 0), rq(1, 0, 0, 32'h4, 0), 1, 0, 32'hA5A5_0000, 0);
        step(rq(1, 0, 0, 32'h0, 0), rq(1, 0, 0, 32'h4, 0), 0, 1, 0, 32'hA5A5_0004);
        step(rq(1, 0, 0, 32'h0, 0), rq(1, 0, 0, 32'h4, 0), 1, 0, 32'hA5A5_0000, 0);
        step(rq(1, 0, 0, 32'h0, 0), rq(1, 0, 0, 32'h4, 0), 0, 1, 0, 32'hA5A5_0004);

        // Lock by requester 0; requester 1 waits until the unlocking read.
        step(rq(1, 1, 1, 32'h8, 32'hDEAD_BEEF), rq(1, 0, 0, 32'h4, 0), 1, 0, 0, 0);
        step(idle, rq(1, 0, 0, 32'h4, 0), 0, 0, 0, 0);
        step(rq(1, 0, 0, 32'h8, 0), rq(1, 0, 0, 32'h4, 0), 1, 0, 32'hDEAD_BEEF, 0);
        step(idle, rq(1, 0, 0, 32'h4, 0), 0, 1, 0, 32'hA5A5_0004);

        // Write then read the same word back to back.
        step(idle, rq(1, 1, 0, 32'h10, 32'h1234_5678), 0, 1, 0, 0);
        step(idle, rq(1, 0, 0, 32'h10, 0), 0, 1, 0, 32'h1234_5678);

        step(idle, idle, 0, 0, 0, 0);
        step(idle, idle, 0, 0, 0, 0);

        // Requester 1 owns the memory while idle; requester 0 stays blocked.
        step(idle, rq(1, 0, 1, 32'h4, 0), 0, 1, 0, 32'hA5A5_0004);
        for (int i = 0; i < 3; i++) step(rq(1, 0, 0, 32'h0, 0), idle, 0, 0, 0, 0);
        step(rq(1, 0, 0, 32'h0, 0), rq(1, 0, 0, 32'h10, 0), 0, 1, 0, 32'h1234_5678);
        step(rq(1, 0, 0, 32'h0, 0), idle, 1, 0, 32'hA5A5_0000, 0);

        // Reset restores the pointer: last winner was 0, yet 0 wins the next contest.
        #2;
        do_reset();
        step(rq(1, 0, 0, 32'h0, 0), rq(1, 0, 0, 32'h4, 0), 1, 0, 32'hA5A5_0000, 0);

        // Reset while owned with a completion pending: pulse dropped, ownership released.
        drive(rq(1, 0, 1, 32'h8, 0), idle);
        #1;
        check("lock_before_reset", 32'(req0_ready), 32'd1);
        @(posedge clock);
        #2;
        do_reset();
        step(idle, rq(1, 0, 0, 32'h4, 0), 0, 1, 0, 32'hA5A5_0004);

        step(idle, idle, 0, 0, 0, 0);
        step(idle, idle, 0, 0, 0, 0);
        check("drain_q0", 32'(sbq[0].size()), 32'd0);
        check("drain_q1", 32'(sbq[1].size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
